// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge arbiter and the device address decoder:
// FSM encoding, one-hot device selects and the default address map.
package bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // One-hot device select, bit order {TC1, TC0, DM}
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_DM   = 3'b001;
    localparam logic [2:0] SEL_TC0  = 3'b010;
    localparam logic [2:0] SEL_TC1  = 3'b100;

    // Default address map
    localparam logic [31:0] DM_HI_DEF    = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] TC_SPAN      = 32'h0000_000B;

    // Timer COUNT register offset; read-only
    localparam logic [3:0]  TC_COUNT_OFF   = 4'h8;
    localparam logic [31:0] TC_COUNT_OFF32 = {28'h0, TC_COUNT_OFF};

    // True when addr lies in base..base+TC_SPAN, written to avoid wrap-around
    function automatic logic in_tc_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && ((addr - base) <= TC_SPAN);
    endfunction

endpackage

// File: rtl/bridge_arbiter_addr_decode.sv
// Combinational device decoder: maps a byte address to a one-hot device
// select and flags unmapped, misaligned or read-only-violating accesses.
module bridge_arbiter_addr_decode
    import bridge_pkg::*;
#(
    parameter logic [31:0] DM_HI    = DM_HI_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic [2:0]  sel_o,
    output logic        err_o
);

    logic is_count;

    // Window match, then the three error sources
    always_comb begin
        sel_o    = SEL_NONE;
        is_count = 1'b0;
        if (addr_i <= DM_HI) begin
            sel_o = SEL_DM;
        end else if (in_tc_window(addr_i, TC0_BASE)) begin
            sel_o    = SEL_TC0;
            is_count = ((addr_i - TC0_BASE) == TC_COUNT_OFF32);
        end else if (in_tc_window(addr_i, TC1_BASE)) begin
            sel_o    = SEL_TC1;
            is_count = ((addr_i - TC1_BASE) == TC_COUNT_OFF32);
        end
        err_o = (sel_o == SEL_NONE) || (addr_i[1:0] != 2'b00) || (we_i && is_count);
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Two-master round-robin arbiter and fixed-length transfer sequencer in front
// of the system bridge. Every output is a flop.
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 1,
    parameter logic [31:0] DM_HI      = DM_HI_DEF,
    parameter logic [31:0] TC0_BASE   = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE   = TC1_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_done,
    output logic        m_err,
    output logic [31:0] m_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [2:0]  bus_sel,
    input  logic [31:0] bus_rdata
);

    // Counter value of the last ACCESS cycle (strobe / capture cycle)
    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_we_q, bus_we_d;
    logic [2:0]  sel_q, sel_d;
    logic        lat_we_q, lat_we_d;
    logic        lat_err_q, lat_err_d;

    logic        win;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_we;
    logic [2:0]  dec_sel;
    logic        dec_err;

    // Winner selection: single requester wins, a tie goes to the master that was not last
    always_comb begin
        if (m_req == 2'b10) begin
            win = 1'b1;
        end else if (m_req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = 1'b0;
        end
        win_addr  = win ? m1_addr  : m0_addr;
        win_wdata = win ? m1_wdata : m0_wdata;
        win_we    = win ? m_we[1]  : m_we[0];
    end

    bridge_arbiter_addr_decode #(
        .DM_HI    (DM_HI),
        .TC0_BASE (TC0_BASE),
        .TC1_BASE (TC1_BASE)
    ) u_addr_decode (
        .addr_i (win_addr),
        .we_i   (win_we),
        .sel_o  (dec_sel),
        .err_o  (dec_err)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        err_d     = err_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bus_we_d  = 1'b0;
        sel_d     = sel_q;
        lat_we_d  = lat_we_q;
        lat_err_d = lat_err_q;

        unique case (state_q)
            StIdle: begin
                if (m_req != 2'b00) begin
                    last_d    = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    addr_d    = win_addr;
                    wdata_d   = win_wdata;
                    lat_we_d  = win_we;
                    lat_err_d = dec_err;
                    sel_d     = dec_err ? SEL_NONE : dec_sel;
                    cnt_d     = 4'd0;
                    // Single-cycle access: the first ACCESS cycle is the strobe cycle
                    bus_we_d  = (ACC_LAST == 4'd0) && win_we && !dec_err;
                    err_d     = 1'b0;
                    rdata_d   = 32'h0;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ACC_LAST) begin
                    sel_d   = SEL_NONE;
                    done_d  = gnt_q;
                    err_d   = lat_err_q;
                    rdata_d = (!lat_err_q && !lat_we_q) ? bus_rdata : 32'h0;
                    state_d = StResp;
                end else begin
                    // Strobe is registered, so arm it one cycle ahead
                    bus_we_d = ((cnt_q + 4'd1) == ACC_LAST) && lat_we_q && !lat_err_q;
                end
            end
            StResp: begin
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                rdata_d = 32'h0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            bus_we_q  <= 1'b0;
            sel_q     <= SEL_NONE;
            lat_we_q  <= 1'b0;
            lat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bus_we_q  <= bus_we_d;
            sel_q     <= sel_d;
            lat_we_q  <= lat_we_d;
            lat_err_q <= lat_err_d;
        end
    end

    assign m_gnt     = gnt_q;
    assign m_done    = done_q;
    assign m_err     = err_q;
    assign m_rdata   = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = sel_q;

endmodule
